// File: rtl/frame_mem_arbiter.sv
// Arbitrates a single-port frame memory between queued pixel writes from the
// packet parser and display reads, with a bounded read-over-write priority.
module frame_mem_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH) + 1,
    localparam int SW = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [23:0]   pixel_data_packet,
    input  logic          msg_ready_in,
    input  logic          rx_en,
    input  logic          rd_req,
    input  logic [15:0]   rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [15:0]   mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [CW-1:0] fifo_count,
    output logic [7:0]    drop_count,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_RESP} state_e;

    state_e        state_q, state_d;
    logic [23:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [SW-1:0] starve_q;
    logic [7:0]    drop_q;
    logic [15:0]   rd_addr_q, mem_addr_q;
    logic [7:0]    mem_wdata_q, rd_data_q;

    logic        full, enq, drop, deq, pending, starved;
    logic [23:0] head;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign enq     = msg_ready_in && rx_en && !full;
    assign drop    = msg_ready_in && rx_en && full;
    assign deq     = (state_q == S_WR);
    // Entries still waiting once this cycle's write has retired; a same-cycle enqueue is not yet visible.
    assign pending = ((count_q - CW'(deq)) != '0);
    assign starved = (starve_q == SW'(STARVE_MAX)) && pending;
    assign head    = fifo_mem[rd_ptr_q];

    assign fifo_count = count_q;
    assign drop_count = drop_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RD:    state_d = S_RD_RESP;
            default: begin
                if (rd_req && !starved) state_d = S_RD;
                else if (pending)       state_d = S_WR;
                else                    state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        rd_gnt    = 1'b0;
        rd_valid  = 1'b0;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        rd_data   = rd_data_q;
        case (state_q)
            S_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = head[23:8];
                mem_wdata = head[7:0];
            end
            S_RD: begin
                mem_en   = 1'b1;
                rd_gnt   = 1'b1;
                mem_addr = rd_addr_q;
            end
            S_RD_RESP: begin
                rd_valid = 1'b1;
                rd_data  = mem_rdata;
            end
            default: ;
        endcase
    end

    // NOTE: state updates use <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            drop_q      <= '0;
            rd_addr_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(enq) - CW'(deq);

            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;

            if (!pending || state_d == S_WR) starve_q <= '0;
            else if (state_d == S_RD)        starve_q <= starve_q + SW'(1);

            if (state_d == S_RD) rd_addr_q <= rd_addr;

            // Hold the last bus/read values through idle and turnaround cycles.
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
            rd_data_q   <= rd_data;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr_q] <= pixel_data_packet;
    end

endmodule

// File: doc/frame_mem_arbiter.md
FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, pending-write FIFO entries; power of 2, at least 2.
REQ-002 Parameter STARVE_MAX, default 8, maximum consecutive read grants while a write is pending.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 pixel_data_packet  in  24  {row[23:16], col[15:8], val[7:0]} from parser.
REQ-006 msg_ready_in  in  1  one-cycle pulse, packet valid.
REQ-007 rx_en  in  1  RX mode level; packets accepted only while high.
REQ-008 rd_req  in  1  display read request; held until rd_gnt.
REQ-009 rd_addr  in  16  {row,col} read address; held with rd_req.
REQ-010 rd_gnt  out  1  read issued this cycle.
REQ-011 rd_valid  out  1  rd_data valid, one-cycle pulse.
REQ-012 rd_data  out  8  read pixel value.
REQ-013 mem_en / mem_we  out  1 each  single-port frame memory enable / write enable.
REQ-014 mem_addr  out  16, mem_wdata  out  8, mem_rdata  in  8  memory bus; synchronous read, data valid the cycle after mem_en with mem_we low.
REQ-015 fifo_count  out  clog2(FIFO_DEPTH)+1  pending writes.
REQ-016 drop_count  out  8  dropped packets, saturating.
REQ-017 busy  out  1  high when state is not IDLE or fifo_count is nonzero.

Function
REQ-018 FSM states: IDLE, WR, RD, RD_RESP; state register holds the memory operation of the current cycle.
REQ-019 Enqueue at the clock edge when msg_ready_in=1, rx_en=1 and FIFO not full.
REQ-020 Fullness is evaluated before a same-cycle dequeue: if full, the packet is dropped even when a dequeue occurs in that cycle.
REQ-021 A dropped packet increments drop_count, which saturates at 255; msg_ready_in with rx_en=0 is ignored and not counted.
REQ-022 Packets already in the FIFO drain normally after rx_en falls.
REQ-023 Next-state decision from IDLE, WR, RD_RESP: if rd_req=1 and not (starve_cnt==STARVE_MAX and FIFO nonempty), go to RD; else if FIFO nonempty, go to WR; else go to IDLE.
REQ-024 RD always goes to RD_RESP; no memory access is issued in RD_RESP (turnaround cycle).
REQ-025 starve_cnt increments on each entry to RD while the FIFO is nonempty; it clears on entry to WR or whenever the FIFO is empty.
REQ-026 In WR: mem_en=1, mem_we=1, mem_addr={row,col} of the FIFO head, mem_wdata=val; the head is dequeued at the end of the cycle.
REQ-027 In RD: mem_en=1, mem_we=0, mem_addr=rd_addr sampled at the decision edge, rd_gnt=1.
REQ-028 In RD_RESP: rd_valid=1 and rd_data=mem_rdata; in all other states rd_valid=0 and rd_data holds its last value.
REQ-029 In IDLE and RD_RESP: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last values.
REQ-030 Read latency: rd_req sampled at edge N (no write priority) gives rd_gnt in cycle N+1 and rd_valid in cycle N+2.
REQ-031 Write latency: msg_ready_in at edge N into an empty FIFO with idle arbiter gives mem_we in cycle N+2.
REQ-032 The FIFO preserves packet order; pointers wrap modulo FIFO_DEPTH.
REQ-033 A write to the same address as a subsequent read is committed before the read only if it is granted earlier; no forwarding.

Reset
REQ-034 reset=0 asynchronously forces state=IDLE, FIFO empty, starve_cnt=0, drop_count=0, rd_gnt=0, rd_valid=0, rd_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-035 Reset asserted mid-operation discards queued writes and any in-flight read; no rd_valid is produced afterwards for that read.

Verification
REQ-036 Single write: rx_en=1, packet 0x07_01_05 pulsed at edge N -> mem_we=1, mem_addr=0x0701, mem_wdata=0x05 in cycle N+2; fifo_count returns to 0.
REQ-037 Read: memory holds 0xFF at 0x7EC8, rd_req with rd_addr=0x7EC8 -> rd_gnt one cycle later, rd_valid with rd_data=0xFF the next cycle.
REQ-038 Overflow: 6 back-to-back packets with rd_req held high (writes blocked) -> fifo_count=4, drop_count=2; first 4 packets are written in order.
REQ-039 Starvation: 1 queued write and rd_req held continuously -> exactly 8 read grants, then one WR cycle, then reads resume.
REQ-040 Gating: packet pulsed with rx_en=0 -> no enqueue, drop_count unchanged; drop_count saturates at 255 after 300 drops.
REQ-041 Reset mid-RD with 3 queued writes -> all outputs at reset values, fifo_count=0, no rd_valid follows.
